microop_sequencer: RTL and testbench

//  Holds the current opcode register and micro-op counter and drives the 11-bit microcode address.

---
 rtl/microop_sequencer_pkg.sv | 15 +
 rtl/microop_counter.sv | 19 +
 rtl/microop_sequencer.sv | 58 +++++
 tb/tb_microop_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/microop_sequencer_pkg.sv
// microop_sequencer_pkg: microcode field positions, encodings and widths for the sequencer
package microop_sequencer_pkg;
  localparam int OPCODE_WIDTH = 6;
  localparam int COUNT_WIDTH = 5;
  localparam int IN_PLANE_LSB = 12;
  localparam int IN_PLANE_W = 3;
  localparam int MISC_LSB = 15;
  localparam int OPCODE_SEL_LSB = 22;
  localparam logic [IN_PLANE_W-1:0] IN_OPCODE = 3'd6;
  localparam logic MISC_RESET_MICROOP_COUNTER = 1'b1;
  localparam logic OPCODE_SEL_OPCODE_FROM_OPWORD = 1'b0;
  localparam logic OPCODE_SEL_OPCODE_FROM_BUS = 1'b1;
  localparam logic [OPCODE_WIDTH-1:0] OP_RESET = 6'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_FETCH = 6'd1;
endpackage

// File: rtl/microop_counter.sv
// microop_counter: micro-op step counter with sync clear, enable and terminal-count flag
module microop_counter
  import microop_sequencer_pkg::*;
#(
  parameter int W = COUNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + W'(1);
  assign tc = &count;
endmodule

// File: rtl/microop_sequencer.sv
// microop_sequencer: opcode register + micro-op counter driving the microcode address; MICROOP_WATCHDOG_EN adds the counter-wrap watchdog
module microop_sequencer
  import microop_sequencer_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_WIDTH,
  parameter int COUNT_W = COUNT_WIDTH,
  parameter logic [OPCODE_W-1:0] OP_RESET_V = OP_RESET
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        n_booted,
  input  logic                        stall,
  input  logic [31:0]                 ucode,
  input  logic [31:0]                 bus,
  input  logic [31:0]                 opword,
  output logic [OPCODE_W+COUNT_W-1:0] addr,
  output logic [OPCODE_W-1:0]         opcode,
  output logic [COUNT_W-1:0]          microop_count,
  output logic                        insn_retire,
  output logic                        fault
);
  logic run, ld, rst_cnt, tc, trip;
  logic [OPCODE_W-1:0] opcode_src;
  assign run = !n_booted && !stall;
  assign ld = ucode[IN_PLANE_LSB +: IN_PLANE_W] == IN_OPCODE;
  assign rst_cnt = ucode[MISC_LSB] == MISC_RESET_MICROOP_COUNTER;
  assign opcode_src = ucode[OPCODE_SEL_LSB] == OPCODE_SEL_OPCODE_FROM_BUS ? bus[OPCODE_W-1:0] : opword[31 -: OPCODE_W];
  logic unused_bits;
  assign unused_bits = ^{ucode[31:OPCODE_SEL_LSB+1], ucode[OPCODE_SEL_LSB-1:MISC_LSB+1], ucode[IN_PLANE_LSB-1:0],
                         bus[31:OPCODE_W], opword[31-OPCODE_W:0], tc};
`ifdef MICROOP_WATCHDOG_EN
  // Only a running step can trip: stalls and boot hold never advance the counter.
  assign trip = run && tc && !rst_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) fault <= 1'b0;
    else if (trip) fault <= 1'b1;
`else
  assign trip = 1'b0;
  assign fault = 1'b0;
`endif
  microop_counter #(.W(COUNT_W)) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (n_booted || (run && (rst_cnt || trip))),
    .en   (run),
    .count(microop_count),
    .tc   (tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opcode <= OP_RESET_V;
      insn_retire <= 1'b0;
    end else begin
      opcode <= n_booted ? OP_RESET_V : !run ? opcode : trip ? OP_RESET_V : ld ? opcode_src : opcode;
      insn_retire <= run && ld && rst_cnt && !trip;
    end
  assign addr = {opcode, microop_count};
endmodule

// File: tb/tb_microop_sequencer.sv
// tb_microop_sequencer: directed stimulus checked every cycle against a spec-level model
module tb_microop_sequencer;
  logic clk = 1'b0, rst = 1'b1, n_booted = 1'b1, stall = 1'b0;
  logic [31:0] ucode = '0, bus = '0, opword = '0;
  logic [10:0] addr;
  logic [5:0] opcode;
  logic [4:0] microop_count;
  logic insn_retire, fault;
  int n_cmp = 0, n_bad = 0;
  int m_op = 0, m_cnt = 0;
  bit m_ret = 0, m_fault = 0;
`ifdef MICROOP_WATCHDOG_EN
  localparam bit WD = 1;
`else
  localparam bit WD = 0;
`endif
  microop_sequencer dut (
    .clk(clk), .rst(rst), .n_booted(n_booted), .stall(stall), .ucode(ucode), .bus(bus),
    .opword(opword), .addr(addr), .opcode(opcode), .microop_count(microop_count),
    .insn_retire(insn_retire), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_op = 0; m_cnt = 0; m_ret = 0; m_fault = 0;
    end else if (n_booted) begin
      m_op = 0; m_cnt = 0; m_ret = 0;
    end else if (stall) m_ret = 0;
    else if (WD && m_cnt == 31 && !ucode[15]) begin
      m_op = 0; m_cnt = 0; m_ret = 0; m_fault = 1;
    end else begin
      if (ucode[14:12] == 3'd6) m_op = ucode[22] ? int'(bus[5:0]) : int'(opword[31:26]);
      m_ret = ucode[14:12] == 3'd6 && ucode[15];
      m_cnt = ucode[15] ? 0 : (m_cnt + 1) % 32;
    end
  always @(negedge clk)
    if (!rst) begin
      chk("model_addr", int'(addr), m_op * 32 + m_cnt);
      chk("model_opcode", int'(opcode), m_op);
      chk("model_count", int'(microop_count), m_cnt);
      chk("model_retire", int'(insn_retire), int'(m_ret));
      chk("model_fault", int'(fault), int'(m_fault));
    end
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  function automatic logic [31:0] uw(input bit ld, input bit rc, input bit sel);
    return {9'd0, sel, 6'd0, rc, ld ? 3'd6 : 3'd0, 12'hABC};
  endfunction
  initial begin
    #12;
    chk("reset_addr", int'(addr), 0);
    chk("reset_fault", int'(fault), 0);
    rst = 1'b0; n_booted = 1'b0;
    cyc(); chk("t1_addr1", int'(addr), 'h001);
    cyc(); chk("t1_addr2", int'(addr), 'h002);
    rst = 1'b1; #1 rst = 1'b0;
    chk("t1_rst", int'(addr), 'h000);
    cyc(); chk("t2_pre", int'(addr), 'h001);
    ucode = uw(1, 1, 1); bus = 32'hFFFF_FFC1;
    cyc(); chk("t2_addr", int'(addr), 'h020); chk("t2_retire", int'(insn_retire), 1);
    ucode = 32'h0;
    cyc(); chk("t2_addr_next", int'(addr), 'h021); chk("t2_retire_off", int'(insn_retire), 0);
    ucode = uw(1, 1, 0); opword = 32'h0C00_0000;
    cyc(); chk("t3_addr", int'(addr), 'h060);
    ucode = uw(1, 1, 1); bus = 32'd2;
    cyc(); ucode = 32'h0;
    cyc(2); chk("t4_pre", int'(addr), 'h042);
    stall = 1'b1; ucode = uw(1, 1, 1); bus = 32'd5;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("t4_stall", int'(addr), 'h042); chk("t4_stall_ret", int'(insn_retire), 0);
    end
    stall = 1'b0;
    cyc(); chk("t4_release", int'(addr), 'h0A0); chk("t4_release_ret", int'(insn_retire), 1);
    ucode = 32'h0;
    cyc(3); chk("t5_pre", int'(addr), 'h0A3);
    n_booted = 1'b1; ucode = uw(1, 1, 1);
    cyc(); chk("t5_boot", int'(addr), 'h000);
    cyc(); chk("t5_boot_hold", int'(addr), 'h000);
    n_booted = 1'b0; ucode = 32'h0;
    cyc(); chk("t5_boot_run", int'(addr), 'h001);
    cyc(); chk("t5_pre_rst", int'(addr), 'h002);
    #1 rst = 1'b1; #1;
    chk("t5_async_rst", int'(addr), 'h000);
    @(negedge clk); #1 rst = 1'b0;
    cyc(); chk("t5_after_rst", int'(addr), 'h001);
    ucode = uw(1, 1, 1); bus = 32'h3F;
    cyc(); chk("t6_load", int'(addr), 'h7E0);
    ucode = uw(1, 0, 1); bus = 32'd4;
    cyc(); chk("ld_only", int'(addr), 'h081);
    ucode = uw(0, 1, 1); bus = 32'd9;
    cyc(); chk("rc_only", int'(addr), 'h080); chk("rc_only_ret", int'(insn_retire), 0);
    ucode = uw(1, 1, 1); bus = 32'h3F;
    cyc(); ucode = 32'h0;
    cyc(31); chk("t6_max", int'(addr), 'h7FF);
    ucode = uw(1, 0, 1); bus = 32'd7;
    cyc();
    if (WD) begin
      chk("t6_wd_addr", int'(addr), 'h000); chk("t6_wd_fault", int'(fault), 1);
    end else begin
      chk("t6_wrap_addr", int'(addr), 'h0E0); chk("t6_wrap_fault", int'(fault), 0);
    end
    ucode = 32'h0;
    cyc(4);
    chk("t6_fault_sticky", int'(fault), int'(WD));
    #1 rst = 1'b1; #1;
    chk("t6_fault_clear", int'(fault), 0);
    @(negedge clk); #1 rst = 1'b0;
    ucode = uw(1, 1, 1); bus = 32'h3F;
    cyc(); ucode = 32'h0;
    cyc(32);
    chk("t6_plain_wrap", int'(addr), WD ? 'h000 : 'h7E0);
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
